keccak_sponge_ctrl: RTL
=======================

// Module: keccak_sponge_ctrl
// PURPOSE
//  Sequences the Keccak f_permutation core for one sponge hash at a time. Takes padded 576-bit
//  rate blocks from the padder, clears the permutation state at message start, feeds each block,
//  waits for all 24 rounds and captures the 512-bit digest. Sits between padder and f_permutation.
// PARAMETERS
//  RATE_BITS    576  width of one absorbed block (must match f_permutation input)
//  DIGEST_BITS  512  digest width, taken from perm_state MSBs
//  CNT_W        16   width of blk_count
//  TIMEOUT      32   max cycles in S_RUN waiting for perm_out_ready before err
// PORTS
//  clk           in   1            clock, all state on rising edge
//  reset         in   1            asynchronous, active-high; clears all state
//  blk_in        in   RATE_BITS    padded block from padder
//  blk_valid     in   1            blk_in valid
//  blk_last      in   1            block is final of message; sampled with blk_ack
//  blk_ack       out  1            block consumed this cycle
//  perm_clr      out  1            one-cycle sync clear to f_permutation state
//  perm_in       out  RATE_BITS    block to f_permutation
//  perm_in_ready out  1            block offered to f_permutation
//  perm_ack      in   1            f_permutation accepted block this cycle
//  perm_out_ready in  1            f_permutation rounds complete (level)
//  perm_state    in   DIGEST_BITS  f_permutation state bits [1599:1599-DIGEST_BITS+1]
//  digest        out  DIGEST_BITS  captured hash
//  digest_valid  out  1            digest held valid until digest_ack
//  digest_ack    in   1            consumer took digest
//  busy          out  1            state != S_IDLE
//  blk_count     out  CNT_W        blocks absorbed in current message
//  err           out  1            sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset (async): state=S_IDLE; blk_ack, perm_clr, perm_in_ready, digest_valid, busy, err = 0;
//   digest=0, blk_count=0. Reset mid-message abandons it; no digest is produced.
//  FSM, one-hot or encoded:
//   S_IDLE: blk_valid=1 -> perm_clr=1 (registered, exactly 1 cycle), blk_count<=0, -> S_CLR.
//           blk_ack=0 here; the first block waits.
//   S_CLR : one cycle, lets clear land -> S_FEED.
//   S_FEED: perm_in=blk_in, perm_in_ready=blk_valid (combinational); blk_ack=perm_ack.
//           On perm_ack: last_q<=blk_last, blk_count<=blk_count+1 (saturates at all-ones),
//           wdog<=0 -> S_RUN. No ack while blk_valid=0.
//   S_RUN : perm_in_ready=0, blk_ack=0. wdog increments each cycle. Ignore perm_out_ready in
//           first cycle of S_RUN (core lowers it the cycle after accept). Then
//           perm_out_ready=1 & last_q -> digest<=perm_state, -> S_DONE;
//           perm_out_ready=1 & !last_q -> S_FEED; wdog==TIMEOUT-1 without it -> err<=1, S_IDLE.
//   S_DONE: digest_valid=1, digest stable. digest_ack=1 -> -> S_IDLE next cycle.
//           blk_valid present here is not acked until the next S_IDLE->S_CLR pass.
//  Latency: block accept -> perm_out_ready nominally 24 cycles; last-block ack -> digest_valid
//   = perm latency + 1. Single-block message: blk_valid -> blk_ack >= 2 cycles (IDLE, CLR).
//  perm_in is pure passthrough; no block buffering. blk_ack and perm_ack are never high outside
//   S_FEED. perm_clr never coincides with perm_in_ready.
//  digest_ack outside S_DONE is ignored. blk_last with blk_count saturating still ends message.
// TESTING
//  T1 single block, blk_last=1, real f_permutation: perm_clr pulse 1 cycle, one ack,
//     digest_valid ~25 cycles later; digest = Keccak-512 of empty string after padding.
//  T2 3-block message: exactly 3 acks, each >=24 cycles apart, blk_count=3, one digest.
//  T3 two messages back-to-back, digest_ack same cycle digest_valid rises: second message gets
//     fresh perm_clr; digest2 independent of message 1.
//  T4 hold digest_ack=0 for 100 cycles with blk_valid=1: digest stable, blk_ack stays 0.
//  T5 stub core never raises perm_out_ready: err=1 after TIMEOUT cycles in S_RUN, busy=0.
//  T6 assert reset mid-S_RUN (async, off-edge): all outputs 0 immediately, blk_count=0, no digest.

Source files
------------

// File: rtl/keccak_sponge_ctrl.sv
// Sponge sequencer for the Keccak f_permutation core. It handles one message at a time.
// At message start it clears the permutation state. It then feeds each padded rate block
// and waits for the rounds to finish. After the final block it captures the digest from
// the top of the permutation state. A watchdog flags a core that never finishes its rounds.
module keccak_sponge_ctrl #(
    parameter int RATE_BITS   = 576,
    parameter int DIGEST_BITS = 512,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RATE_BITS-1:0]   blk_in,
    input  logic                   blk_valid,
    input  logic                   blk_last,
    output logic                   blk_ack,
    output logic                   perm_clr,
    output logic [RATE_BITS-1:0]   perm_in,
    output logic                   perm_in_ready,
    input  logic                   perm_ack,
    input  logic                   perm_out_ready,
    input  logic [DIGEST_BITS-1:0] perm_state,
    output logic [DIGEST_BITS-1:0] digest,
    output logic                   digest_valid,
    input  logic                   digest_ack,
    output logic                   busy,
    output logic [CNT_W-1:0]       blk_count,
    output logic                   err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic             last_q;
    logic [WD_W-1:0]  wdog;
    logic             feed_accept;

    // Blocks pass straight through to the core. Nothing is buffered, so an accept by the
    // core in S_FEED is exactly the moment the padder's block is consumed.
    always_comb begin
        perm_in       = blk_in;
        perm_in_ready = (state == S_FEED) && blk_valid;
        feed_accept   = perm_in_ready && perm_ack;
        blk_ack       = feed_accept;
    end

    // Sponge sequencing FSM with registered control and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            perm_clr     <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            blk_count    <= '0;
            err          <= 1'b0;
            last_q       <= 1'b0;
            wdog         <= '0;
        end else begin
            perm_clr <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The first block is not acked here. It waits until the clear has landed.
                    if (blk_valid) begin
                        perm_clr  <= 1'b1;
                        blk_count <= '0;
                        busy      <= 1'b1;
                        state     <= S_CLR;
                    end
                end
                S_CLR: begin
                    state <= S_FEED;
                end
                S_FEED: begin
                    if (feed_accept) begin
                        last_q <= blk_last;
                        if (blk_count != '1) begin
                            blk_count <= blk_count + CNT_W'(1);
                        end
                        wdog  <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    wdog <= wdog + WD_W'(1);
                    // perm_out_ready may still be high from the previous run in the first
                    // cycle (wdog == 0). The core only drops it after the accept.
                    if ((wdog != '0) && perm_out_ready) begin
                        if (last_q) begin
                            digest       <= perm_state;
                            digest_valid <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            state <= S_FEED;
                        end
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (digest_ack) begin
                        digest_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    digest_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule
